approx_38x16_signed_div: RTL

Iterative signed divider, the inverse companion of the approximate 22x16 signed multiplier. It takes a 38-bit signed dividend (product-width) and a 16-bit signed divisor, and returns a 22-bit signed quotient and a 16-bit signed remainder. Arithmetic is sign-magnitude restoring division at one quotient bit per cycle. precise_en trades accuracy for latency by truncating the low quotient bits.

---
 rtl/approx_38x16_signed_div.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/approx_38x16_signed_div.sv
// approx_38x16_signed_div
//
// Iterative signed divider using sign-magnitude restoring division at one
// quotient bit per cycle. Takes a DIVIDEND_W-bit signed dividend and a
// DIVISOR_W-bit signed divisor. Returns a QUOT_W-bit signed quotient, which
// is truncated toward zero and saturated, and a DIVISOR_W-bit signed
// remainder that carries the sign of the dividend.
//
// When precise_en=0, the low APPROX_SKIP quotient bits are never computed.
// They are forced to zero, which trims APPROX_SKIP cycles from the latency.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE, and out_valid is high only in
// DONE. The two are never high together, so a result handoff and a new
// accept cannot share a cycle. A producer that raises in_valid while the
// block is busy is ignored and must hold its request.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid / in_ready   operand handshake
//   dividend, divisor     signed operands
//   precise_en            1 = full precision, 0 = approximate (sampled at accept)
//   out_valid / out_ready result handshake
//   quotient, remainder   signed results, held from the FIXUP->DONE edge
//   overflow              quotient was saturated
//   div_by_zero           divisor was zero
//   busy                  block is not IDLE
//   state_dbg             current FSM state (IDLE=0, CALC=1, FIXUP=2, DONE=3)
module approx_38x16_signed_div #(
   parameter int DIVIDEND_W  = 38,
   parameter int DIVISOR_W   = 16,
   parameter int QUOT_W      = 22,
   parameter int APPROX_SKIP = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DIVIDEND_W-1:0] dividend,
   input  logic [DIVISOR_W-1:0]  divisor,
   input  logic                  precise_en,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [QUOT_W-1:0]     quotient,
   output logic [DIVISOR_W-1:0]  remainder,
   output logic                  overflow,
   output logic                  div_by_zero,
   output logic                  busy,
   output logic [1:0]            state_dbg
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CALC  = 2'd1,
      FIXUP = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int CNT_W = $clog2(DIVIDEND_W + 1);
   localparam int PW    = DIVISOR_W + 1;

   localparam logic [CNT_W-1:0] N_PRECISE = CNT_W'(DIVIDEND_W);
   localparam logic [CNT_W-1:0] N_APPROX  = CNT_W'(DIVIDEND_W - APPROX_SKIP);

   // Largest magnitudes representable for positive and negative results.
   localparam logic [DIVIDEND_W-1:0] POS_LIM = DIVIDEND_W'((64'd1 << (QUOT_W - 1)) - 64'd1);
   localparam logic [DIVIDEND_W-1:0] NEG_LIM = DIVIDEND_W'(64'd1 << (QUOT_W - 1));
   localparam logic [QUOT_W-1:0]     Q_MAX   = {1'b0, {(QUOT_W - 1){1'b1}}};
   localparam logic [QUOT_W-1:0]     Q_MIN   = {1'b1, {(QUOT_W - 1){1'b0}}};

   state_t state, state_next;

   logic [DIVIDEND_W-1:0] dvd_sh;     // dividend magnitude, consumed MSB first
   logic [DIVISOR_W-1:0]  dsr_mag_q;
   logic [PW-1:0]         part;       // partial remainder
   logic [DIVIDEND_W-1:0] quo;        // quotient bits, shifted in LSB side
   logic [CNT_W-1:0]      cnt;
   logic                  q_sign;
   logic                  r_sign;
   logic                  prec_q;
   logic                  dbz_q;

   // Operand magnitudes. For the most negative dividend, the unsigned
   // negation yields 2^(DIVIDEND_W-1), which is exactly the required
   // magnitude, so it does not wrap.
   logic [DIVIDEND_W-1:0] dvd_mag;
   logic [DIVISOR_W-1:0]  dsr_mag;
   logic                  dsr_is_zero;

   always_comb begin
      dvd_mag     = dividend[DIVIDEND_W-1] ? (~dividend + DIVIDEND_W'(1)) : dividend;
      dsr_mag     = divisor[DIVISOR_W-1]   ? (~divisor + DIVISOR_W'(1))   : divisor;
      dsr_is_zero = (divisor == '0);
   end

   // One restoring step. shifted is one bit wider than part, so the
   // comparison can never overflow.
   logic [PW:0] shifted;
   logic [PW:0] dsr_ext;
   logic        ge;

   always_comb begin
      shifted = {part, dvd_sh[DIVIDEND_W-1]};
      dsr_ext = {2'b00, dsr_mag_q};
      ge      = (shifted >= dsr_ext);
   end

   // Sign application and saturation, evaluated while in FIXUP.
   logic [DIVIDEND_W-1:0] quo_mag;
   logic [QUOT_W-1:0]     q_low;
   logic [DIVISOR_W-1:0]  rem_mag;
   logic [QUOT_W-1:0]     q_fix;
   logic [DIVISOR_W-1:0]  r_fix;
   logic                  of_fix;

   always_comb begin
      // Approximate mode stopped early, so its bits sit APPROX_SKIP too low.
      quo_mag = prec_q ? quo : (quo << APPROX_SKIP);
      q_low   = quo_mag[QUOT_W-1:0];
      rem_mag = part[DIVISOR_W-1:0];
      q_fix   = '0;
      r_fix   = '0;
      of_fix  = 1'b0;
      if (dbz_q) begin
         q_fix = r_sign ? Q_MIN : Q_MAX;
      end else begin
         if (!q_sign) begin
            if (quo_mag > POS_LIM) begin
               q_fix  = Q_MAX;
               of_fix = 1'b1;
            end else begin
               q_fix = q_low;
            end
         end else begin
            if (quo_mag > NEG_LIM) begin
               q_fix  = Q_MIN;
               of_fix = 1'b1;
            end else begin
               q_fix = ~q_low + QUOT_W'(1);
            end
         end
         if (prec_q) begin
            r_fix = r_sign ? (~rem_mag + DIVISOR_W'(1)) : rem_mag;
         end
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state and handshake outputs
   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      busy       = 1'b1;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) begin
               state_next = dsr_is_zero ? FIXUP : CALC;
            end
         end
         CALC: begin
            if (cnt == CNT_W'(1)) begin
               state_next = FIXUP;
            end
         end
         FIXUP: begin
            state_next = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign state_dbg = state;

   // Datapath and result registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dvd_sh      <= '0;
         dsr_mag_q   <= '0;
         part        <= '0;
         quo         <= '0;
         cnt         <= '0;
         q_sign      <= 1'b0;
         r_sign      <= 1'b0;
         prec_q      <= 1'b0;
         dbz_q       <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         overflow    <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  dvd_sh    <= dvd_mag;
                  dsr_mag_q <= dsr_mag;
                  part      <= '0;
                  quo       <= '0;
                  cnt       <= precise_en ? N_PRECISE : N_APPROX;
                  q_sign    <= dividend[DIVIDEND_W-1] ^ divisor[DIVISOR_W-1];
                  r_sign    <= dividend[DIVIDEND_W-1];
                  prec_q    <= precise_en;
                  dbz_q     <= dsr_is_zero;
               end
            end
            CALC: begin
               dvd_sh <= dvd_sh << 1;
               part   <= PW'(ge ? (shifted - dsr_ext) : shifted);
               quo    <= {quo[DIVIDEND_W-2:0], ge};
               cnt    <= cnt - CNT_W'(1);
            end
            FIXUP: begin
               quotient    <= q_fix;
               remainder   <= r_fix;
               overflow    <= of_fix;
               div_by_zero <= dbz_q;
            end
            default: begin
            end
         endcase
      end
   end

endmodule
